// File: rtl/fractal_sync_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fractal_sync_tx
//  Brief    : Fractal-sync link transmitter: round-robin arbitration of two
//             request sources, local request FIFO, credit-gated issue to rx.
//  Revision : 1.0 - initial release
// ============================================================================
module fractal_sync_tx #(
    parameter type fsync_req_t = struct packed {
        logic                  sync;
        struct packed {
            logic [3:0] aggr;
            logic [2:0] id;
        }                      sig;
        logic [1:0]            src;
    },
    parameter bit          COMB_OUT   = 1'b1,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned N_CREDITS  = 1,
    localparam int unsigned CREDIT_W  = $clog2(N_CREDITS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  fsync_req_t          req_a_i,
    output logic                ready_a_o,
    input  fsync_req_t          req_b_i,
    output logic                ready_b_o,
    output fsync_req_t          req_o,
    input  logic                credit_i,
    output logic [CREDIT_W-1:0] credits_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                error_credit_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]    c_depth       = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    c_last_ptr    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CREDIT_W-1:0] c_max_credits = CREDIT_W'(N_CREDITS);

    if (FIFO_DEPTH == 0) begin : g_bad_fifo_depth
        $error("fractal_sync_tx: FIFO_DEPTH must be > 0");
    end
    if (N_CREDITS == 0) begin : g_bad_n_credits
        $error("fractal_sync_tx: N_CREDITS must be > 0");
    end

    fsync_req_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_prio_b;
    logic [CREDIT_W-1:0] r_credits;

    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_push;
    logic       w_send;
    fsync_req_t w_push_data;
    fsync_req_t w_head_out;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Round-robin: r_prio_b selects who wins when both sources are valid.
    assign w_grant_a   = req_a_i.sync & (~req_b_i.sync | ~r_prio_b);
    assign w_grant_b   = req_b_i.sync & (~req_a_i.sync |  r_prio_b);
    assign empty_o     = (r_count == '0);
    assign full_o      = (r_count == c_depth);
    assign ready_a_o   = w_grant_a & ~full_o;
    assign ready_b_o   = w_grant_b & ~full_o;
    assign w_push      = ready_a_o | ready_b_o;
    assign w_push_data = w_grant_a ? req_a_i : req_b_i;
    assign w_send      = ~empty_o & (r_credits != '0);
    assign credits_o   = r_credits;
    assign error_credit_o = credit_i & (r_credits == c_max_credits) & ~w_send;

    always_comb begin
        w_head_out = '0;
        if (w_send) begin
            w_head_out      = r_mem[r_rptr];
            w_head_out.sync = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_prio_b  <= 1'b0;
            r_credits <= c_max_credits;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_send) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_send})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (ready_a_o) begin
                r_prio_b <= 1'b1;
            end else if (ready_b_o) begin
                r_prio_b <= 1'b0;
            end
            // A spurious credit at the ceiling saturates and raises error_credit_o.
            case ({w_send, credit_i})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= (r_credits == c_max_credits) ? r_credits : r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    if (COMB_OUT) begin : g_comb_out
        assign req_o = w_head_out;
    end else begin : g_reg_out
        fsync_req_t r_req_o;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_req_o <= '0;
            end else begin
                r_req_o <= w_head_out;
            end
        end
        assign req_o = r_req_o;
    end

    a_no_send_without_credit: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(w_send && (r_credits == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fractal_sync_tx
//  Brief    : Randomized self-checking bench for fractal_sync_tx, comparing
//             combinational- and registered-output variants to a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fractal_sync_tx;

    typedef struct packed {
        logic [3:0] aggr;
        logic [2:0] id;
    } sig_t;

    typedef struct packed {
        logic       sync;
        sig_t       sig;
        logic [1:0] src;
    } req_t;

    localparam int FIFO_DEPTH = 2;
    localparam int N_CREDITS  = 1;
    localparam int CREDIT_W   = $clog2(N_CREDITS + 1);

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    req_t req_a_i;
    req_t req_b_i;
    logic credit_i;

    logic                ready_a_c, ready_b_c, empty_c, full_c, err_c;
    logic                ready_a_r, ready_b_r, empty_r, full_r, err_r;
    req_t                req_o_c, req_o_r;
    logic [CREDIT_W-1:0] credits_c, credits_r;

    always #5 clk_i = ~clk_i;

    fractal_sync_tx #(
        .fsync_req_t (req_t),
        .COMB_OUT    (1'b1),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .N_CREDITS   (N_CREDITS)
    ) u_dut_comb (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_a_i        (req_a_i),
        .ready_a_o      (ready_a_c),
        .req_b_i        (req_b_i),
        .ready_b_o      (ready_b_c),
        .req_o          (req_o_c),
        .credit_i       (credit_i),
        .credits_o      (credits_c),
        .empty_o        (empty_c),
        .full_o         (full_c),
        .error_credit_o (err_c)
    );

    fractal_sync_tx #(
        .fsync_req_t (req_t),
        .COMB_OUT    (1'b0),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .N_CREDITS   (N_CREDITS)
    ) u_dut_reg (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_a_i        (req_a_i),
        .ready_a_o      (ready_a_r),
        .req_b_i        (req_b_i),
        .ready_b_o      (ready_b_r),
        .req_o          (req_o_r),
        .credit_i       (credit_i),
        .credits_o      (credits_r),
        .empty_o        (empty_r),
        .full_o         (full_r),
        .error_credit_o (err_r)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: request queue, credit count, round-robin owner.
    req_t q[$];
    int   m_credits;
    bit   m_prio_b;
    req_t m_req_r;

    // Source agents: a pending request is held until it is accepted.
    bit   pend_a, pend_b;
    req_t hold_a, hold_b;

    function automatic req_t rnd_req(input logic [1:0] src);
        req_t r;
        r.sync     = 1'b1;
        r.sig.aggr = 4'($urandom);
        r.sig.id   = 3'($urandom);
        r.src      = src;
        return r;
    endfunction

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic cr);
        bit   e, f, ga, gb, ra, rb, snd, eerr;
        req_t ec;
        req_a_i  = pend_a ? hold_a : '0;
        req_b_i  = pend_b ? hold_b : '0;
        credit_i = cr;
        #3;
        e    = (q.size() == 0);
        f    = (q.size() == FIFO_DEPTH);
        ga   = pend_a && (!pend_b || !m_prio_b);
        gb   = pend_b && (!pend_a ||  m_prio_b);
        ra   = ga && !f;
        rb   = gb && !f;
        snd  = !e && (m_credits > 0);
        ec   = '0;
        if (snd) begin
            ec      = q[0];
            ec.sync = 1'b1;
        end
        eerr = cr && (m_credits == N_CREDITS) && !snd;

        chk("ready_a",      32'(ready_a_c), 32'(ra));
        chk("ready_b",      32'(ready_b_c), 32'(rb));
        chk("empty",        32'(empty_c),   32'(e));
        chk("full",         32'(full_c),    32'(f));
        chk("credits",      32'(credits_c), m_credits);
        chk("error_credit", 32'(err_c),     32'(eerr));
        chk("req_o_comb",   32'(req_o_c),   32'(ec));
        chk("reg_ready_a",  32'(ready_a_r), 32'(ra));
        chk("reg_ready_b",  32'(ready_b_r), 32'(rb));
        chk("reg_empty",    32'(empty_r),   32'(e));
        chk("reg_full",     32'(full_r),    32'(f));
        chk("reg_credits",  32'(credits_r), m_credits);
        chk("reg_err",      32'(err_r),     32'(eerr));
        chk("req_o_reg",    32'(req_o_r),   32'(m_req_r));

        if (snd) void'(q.pop_front());
        if (ra) q.push_back(hold_a);
        if (rb) q.push_back(hold_b);
        if (ra)      m_prio_b = 1'b1;
        else if (rb) m_prio_b = 1'b0;
        m_credits = m_credits - int'(snd) + int'(cr);
        if (m_credits > N_CREDITS) m_credits = N_CREDITS;
        m_req_r = ec;
        if (ra) pend_a = 1'b0;
        if (rb) pend_b = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #1;
        credit_i = 1'b0;
        req_a_i  = '0;
        req_b_i  = '0;
        rst_ni   = 1'b0;
        #1;
        chk("rst_empty",       32'(empty_c),   32'd1);
        chk("rst_full",        32'(full_c),    32'd0);
        chk("rst_credits",     32'(credits_c), N_CREDITS);
        chk("rst_req_o_comb",  32'(req_o_c),   32'd0);
        chk("rst_req_o_reg",   32'(req_o_r),   32'd0);
        chk("rst_reg_empty",   32'(empty_r),   32'd1);
        chk("rst_reg_credits", 32'(credits_r), N_CREDITS);
        chk("rst_err",         32'(err_c),     32'd0);
        q.delete();
        m_credits = N_CREDITS;
        m_prio_b  = 1'b0;
        m_req_r   = '0;
        pend_a    = 1'b0;
        pend_b    = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic cr;
        int   outstanding;
        req_a_i  = '0;
        req_b_i  = '0;
        credit_i = 1'b0;
        #6;
        do_reset();

        // Single A request, then a spurious credit at the ceiling.
        pend_a = 1'b1;
        hold_a = '{sync: 1'b1, sig: '{aggr: 4'b0100, id: 3'd3}, src: 2'd0};
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);

        // Both sources contend while credits are withheld: fill, stall, drain.
        for (int i = 0; i < 6; i++) begin
            if (!pend_a) begin pend_a = 1'b1; hold_a = rnd_req(2'd0); end
            if (!pend_b) begin pend_b = 1'b1; hold_b = rnd_req(2'd1); end
            cycle(i == 3);
        end

        // Reset with buffered entries, then confirm nothing stale comes out.
        do_reset();
        cycle(1'b0);
        cycle(1'b0);

        for (int i = 0; i < 3000; i++) begin
            if (!pend_a && $urandom_range(3) != 0) begin pend_a = 1'b1; hold_a = rnd_req(2'($urandom)); end
            if (!pend_b && $urandom_range(3) != 0) begin pend_b = 1'b1; hold_b = rnd_req(2'($urandom)); end
            outstanding = N_CREDITS - m_credits;
            if (outstanding > 0) cr = ($urandom_range(9) < 3);
            else                 cr = ($urandom_range(19) == 0);
            if ($urandom_range(399) == 0) do_reset();
            else                          cycle(cr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
